bcd_updn_counter_n: RTL and testbench

BCD_UPDN_COUNTER_N -- requirements
Module: bcd_updn_counter_n

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 55 +++++
 rtl/bcd_updn_counter_n.sv | 128 ++++++++++++
 tb/tb_bcd_updn_counter_n.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared BCD definitions for the up/down BCD counter.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MIN     : smallest legal digit value (0)
//   BCD_MAX     : largest legal digit value (9)
//   bcd_clamp() : forces any nibble above 9 down to 9
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit -- one decade of the BCD up/down counter.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset, clears the digit
//   step_in    : advance this digit by one (carry/borrow from lower digits)
//   up         : direction, 1 = increment, 0 = decrement
//   load       : load load_digit on the next edge (priority over step_in)
//   load_digit : value to load, already clamped to 0..9 by the parent
//   digit_out  : current digit value
//   at_term    : digit sits at its terminal value for the current
//                direction (9 when up, 0 when down); combinational
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit_out,
  output logic       at_term
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (step_in) begin
      if (up) begin
        // ">=" also recovers from any out-of-range value
        digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX
                : (digit_q > BCD_MAX)  ? BCD_MAX
                : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_out = digit_q;
  assign at_term   = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updn_counter_n.sv
// bcd_updn_counter_n -- DIGITS-decade BCD up/down counter with load,
// dual count enables, terminal-count flag and a registered wrap pulse.
// Parameters:
//   DIGITS   : number of BCD digits (1..8)
//   SATURATE : 1 = hold at the terminal value, 0 = wrap around
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset (count, reload, wrap -> 0)
//   load     : synchronous load of data_in (digits > 9 clamped to 9)
//   enable1  : count enable, ANDed with enable2
//   enable2  : count enable, ANDed with enable1
//   up       : direction, 1 = up, 0 = down
//   data_in  : packed BCD load value, digit 0 in [3:0]
//   count    : packed BCD count, digit 0 in [3:0]
//   tc       : combinational terminal count (all 9s up, all 0s down)
//   wrap     : one-cycle pulse after each terminal step that wrapped
// Build option:
//   BCD_COUNTER_AUTORELOAD_EN : with SATURATE=0, a down-mode terminal
//   step reloads the last loaded (clamped) value instead of 9...9.
module bcd_updn_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                enable1,
  input  logic                enable2,
  input  logic                up,
  input  logic [4*DIGITS-1:0] data_in,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap
);

  localparam int   W   = 4 * DIGITS;
  localparam logic SAT = (SATURATE != 0);

  logic [DIGITS-1:0] at_term;
  logic [DIGITS-1:0] step_in;
  logic [W-1:0]      data_clamped;
  logic [W-1:0]      load_val;
  logic              step_req;
  logic              term_step;
  logic              hold;
  logic              reload_now;
  logic              step_en;
  logic              digit_load;
  logic              wrap_d;
  logic              wrap_q;

  always_comb begin
    data_clamped = '0;
    for (int k = 0; k < DIGITS; k++) begin
      data_clamped[4*k +: 4] = bcd_clamp(data_in[4*k +: 4]);
    end
  end

  assign step_req  = ~load & enable1 & enable2;
  assign tc        = &at_term;
  assign term_step = step_req & tc;
  assign hold      = term_step & SAT;

`ifdef BCD_COUNTER_AUTORELOAD_EN
  logic [W-1:0] reload_q;
  logic [W-1:0] reload_d;

  assign reload_d   = load ? data_clamped : reload_q;
  assign reload_now = term_step & ~up & ~SAT;
  assign load_val   = load ? data_clamped : reload_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  assign reload_now = 1'b0;
  assign load_val   = data_clamped;
`endif

  // A reload replaces the normal wrap, so the step chain is suppressed.
  assign step_en    = step_req & ~hold & ~reload_now;
  assign digit_load = load | reload_now;

  // Ripple carry/borrow: digit k steps only when every lower digit is at
  // its terminal value for the current direction.
  always_comb begin
    logic carry;
    step_in = '0;
    carry   = step_en;
    for (int k = 0; k < DIGITS; k++) begin
      step_in[k] = carry;
      carry      = carry & at_term[k];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .step_in    (step_in[g]),
      .up         (up),
      .load       (digit_load),
      .load_digit (load_val[4*g +: 4]),
      .digit_out  (count[4*g +: 4]),
      .at_term    (at_term[g])
    );
  end

  // Held saturating steps do not pulse; wraps and reloads do.
  assign wrap_d = term_step & ~SAT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_updn_counter_n.sv
// tb_bcd_updn_counter_n -- directed bench for bcd_updn_counter_n.
// Instances: u_a (DIGITS=2, wrap), u_s (DIGITS=2, saturate),
// u_d4 (DIGITS=4, wrap). Control inputs are shared.
module tb_bcd_updn_counter_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        enable1;
  logic        enable2;
  logic        up;
  logic [7:0]  data_in;
  logic [15:0] data_in4;
  logic [7:0]  count_a;
  logic [7:0]  count_s;
  logic [15:0] count_d4;
  logic        tc_a, tc_s, tc_d4;
  logic        wrap_a, wrap_s, wrap_d4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_updn_counter_n #(.DIGITS(2), .SATURATE(0)) u_a (
    .clk(clk), .reset(reset), .load(load), .enable1(enable1),
    .enable2(enable2), .up(up), .data_in(data_in),
    .count(count_a), .tc(tc_a), .wrap(wrap_a)
  );

  bcd_updn_counter_n #(.DIGITS(2), .SATURATE(1)) u_s (
    .clk(clk), .reset(reset), .load(load), .enable1(enable1),
    .enable2(enable2), .up(up), .data_in(data_in),
    .count(count_s), .tc(tc_s), .wrap(wrap_s)
  );

  bcd_updn_counter_n #(.DIGITS(4), .SATURATE(0)) u_d4 (
    .clk(clk), .reset(reset), .load(load), .enable1(enable1),
    .enable2(enable2), .up(up), .data_in(data_in4),
    .count(count_d4), .tc(tc_d4), .wrap(wrap_d4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d, input logic [15:0] d4);
    data_in  = d;
    data_in4 = d4;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; enable1 = 1'b0; enable2 = 1'b0;
    up = 1'b0; data_in = '0; data_in4 = '0;
    #12;
    // reset state
    check("rst_count", {24'h0, count_a}, 32'h00);
    check("rst_wrap", {31'h0, wrap_a}, 32'h0);
    check("rst_tc_down", {31'h0, tc_a}, 32'h1);
    up = 1'b1; #1;
    check("rst_tc_up", {31'h0, tc_a}, 32'h0);
    up = 1'b0;
    #2 reset = 1'b0;
    #1;

    // load 25, count down to 00, then terminal step
    do_load(8'h25, 16'h0);
    check("ld25", {24'h0, count_a}, 32'h25);
    enable1 = 1'b1; enable2 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 0) check("dn_first", {24'h0, count_a}, 32'h24);
      if (i == 5) check("dn_borrow", {24'h0, count_a}, 32'h19);
    end
    check("dn_zero", {24'h0, count_a}, 32'h00);
    check("dn_zero_tc", {31'h0, tc_a}, 32'h1);
    check("dn_zero_wrap", {31'h0, wrap_a}, 32'h0);
    tick();
`ifdef BCD_COUNTER_AUTORELOAD_EN
    check("dn_term", {24'h0, count_a}, 32'h25);
`else
    check("dn_term", {24'h0, count_a}, 32'h99);
`endif
    check("dn_term_wrap", {31'h0, wrap_a}, 32'h1);
    check("sat_dn_hold", {24'h0, count_s}, 32'h00);
    check("sat_dn_wrap", {31'h0, wrap_s}, 32'h0);
    tick();
    check("dn_wrap_clr", {31'h0, wrap_a}, 32'h0);

    // saturating up from 97; load wins over enables
    up = 1'b1;
    do_load(8'h97, 16'h0);
    check("ld97", {24'h0, count_s}, 32'h97);
    begin
      logic [7:0] exp_s [5];
      exp_s = '{8'h98, 8'h99, 8'h99, 8'h99, 8'h99};
      for (int i = 0; i < 5; i++) begin
        tick();
        check($sformatf("sat_up%0d", i), {24'h0, count_s}, {24'h0, exp_s[i]});
        check($sformatf("sat_wrap%0d", i), {31'h0, wrap_s}, 32'h0);
      end
    end
    check("sat_tc", {31'h0, tc_s}, 32'h1);

    // enable gate
    up = 1'b0;
    do_load(8'h42, 16'h0);
    enable2 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("en2_gate", {24'h0, count_a}, 32'h42);
    enable1 = 1'b0; enable2 = 1'b1;
    tick();
    check("en1_gate", {24'h0, count_a}, 32'h42);
    enable2 = 1'b0;
    do_load(8'h3F, 16'h0);
    check("clamp_3f", {24'h0, count_a}, 32'h39);
    do_load(8'hAF, 16'h0);
    check("clamp_af", {24'h0, count_a}, 32'h99);

`ifdef BCD_COUNTER_AUTORELOAD_EN
    // auto-reload on down terminal step
    up = 1'b0; enable1 = 1'b1; enable2 = 1'b1;
    do_load(8'h03, 16'h0);
    check("ar_ld", {24'h0, count_a}, 32'h03);
    begin
      logic [7:0] exp_c [6];
      logic       exp_w [6];
      exp_c = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
        tick();
        check($sformatf("ar_cnt%0d", i), {24'h0, count_a}, {24'h0, exp_c[i]});
        check($sformatf("ar_wrap%0d", i), {31'h0, wrap_a}, {31'h0, exp_w[i]});
      end
    end
    enable1 = 1'b0; enable2 = 1'b0;
`endif

    // asynchronous reset mid-operation at count 47
    enable1 = 1'b0; enable2 = 1'b0;
    do_load(8'h47, 16'h0);
    check("ld47", {24'h0, count_a}, 32'h47);
    #3 reset = 1'b1;
    #1;
    check("arst_count", {24'h0, count_a}, 32'h00);
    check("arst_wrap", {31'h0, wrap_a}, 32'h0);
    #1 reset = 1'b0;
    up = 1'b1; enable1 = 1'b1; enable2 = 1'b1;
    tick();
    check("arst_resume", {24'h0, count_a}, 32'h01);

    // reset clears a live wrap pulse
    do_load(8'h99, 16'h0);
    tick();
    check("up_wrap_cnt", {24'h0, count_a}, 32'h00);
    check("up_wrap", {31'h0, wrap_a}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_wrap_live", {31'h0, wrap_a}, 32'h0);
    #1 reset = 1'b0;

    // four digits
    up = 1'b0;
    do_load(8'h00, 16'h1000);
    check("d4_ld", {16'h0, count_d4}, 32'h1000);
    tick();
    check("d4_borrow", {16'h0, count_d4}, 32'h0999);
    up = 1'b1;
    do_load(8'h00, 16'h9999);
    check("d4_tc", {31'h0, tc_d4}, 32'h1);
    tick();
    check("d4_wrap_cnt", {16'h0, count_d4}, 32'h0000);
    check("d4_wrap", {31'h0, wrap_d4}, 32'h1);
    enable1 = 1'b0;
    tick();
    check("d4_wrap_clr", {31'h0, wrap_d4}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
